// File: rtl/vcve2_vec_ex_seq.sv
// Per-word sequencer that runs one vector arithmetic instruction through the scalar EX
// datapath: read vs2/vs1 words, hand them to EX, write the result word to vd.
module vcve2_vec_ex_seq #(
    parameter int VLEN = 128,
    localparam int NWORDS = VLEN / 32,
    localparam int WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1,
    localparam int VL_W = $clog2(VLEN / 8) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              ready_o,
    output logic              busy_o,
    input  logic [4:0]        vd_i,
    input  logic [4:0]        vs1_i,
    input  logic [4:0]        vs2_i,
    input  logic [VL_W-1:0]   vl_i,
    input  logic [2:0]        vsew_i,
    output logic              vrf_re_o,
    output logic [4:0]        vrf_ra1_o,
    output logic [4:0]        vrf_ra2_o,
    output logic [WORD_W-1:0] vrf_rword_o,
    input  logic [31:0]       vrf_rdata1_i,
    input  logic [31:0]       vrf_rdata2_i,
    output logic [31:0]       ex_operand_a_o,
    output logic [31:0]       ex_operand_b_o,
    output logic              ex_first_cycle_o,
    input  logic              ex_valid_i,
    input  logic [31:0]       ex_result_i,
    output logic              vrf_we_o,
    output logic [4:0]        vrf_wa_o,
    output logic [WORD_W-1:0] vrf_wword_o,
    output logic [31:0]       vrf_wdata_o,
    output logic [3:0]        vrf_wbe_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        dbg_state_o
);

    // Handshake: start_i is taken on any cycle where ready_o=1 (IDLE); it is not held or
    // queued, and start_i while busy is dropped.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         vd_q, vs1_q, vs2_q;
    logic [1:0]         sew_q;
    logic [VL_W-1:0]    rem_q;
    logic [WORD_W-1:0]  word_q;
    logic [31:0]        op_a_q, op_b_q, res_q;
    logic               first_q;

    logic [VL_W-1:0]    elems;
    logic [VL_W-1:0]    vlmax_in;
    logic               sew_legal;
    logic               last_word;
    logic [3:0]         wbe;

    // Elements per word for the latched SEW.
    always_comb begin
        elems = VL_W'(1);
        case (sew_q)
            2'b00:   elems = VL_W'(4);
            2'b01:   elems = VL_W'(2);
            default: elems = VL_W'(1);
        endcase
    end

    always_comb begin
        vlmax_in  = '0;
        sew_legal = 1'b0;
        case (vsew_i)
            3'b000: begin vlmax_in = VL_W'(NWORDS * 4); sew_legal = 1'b1; end
            3'b001: begin vlmax_in = VL_W'(NWORDS * 2); sew_legal = 1'b1; end
            3'b010: begin vlmax_in = VL_W'(NWORDS);     sew_legal = 1'b1; end
            default: begin vlmax_in = '0; sew_legal = 1'b0; end
        endcase
    end

    assign last_word = (rem_q <= elems);

    // Tail word: enable only the bytes of the remaining elements.
    always_comb begin
        wbe = 4'hF;
        if (rem_q < elems) begin
            case (sew_q)
                2'b00: begin
                    case (rem_q[1:0])
                        2'd1:    wbe = 4'b0001;
                        2'd2:    wbe = 4'b0011;
                        2'd3:    wbe = 4'b0111;
                        default: wbe = 4'hF;
                    endcase
                end
                2'b01:   wbe = 4'b0011;
                default: wbe = 4'hF;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (!sew_legal || (vl_i > vlmax_in)) state_d = S_ERR;
                    else if (vl_i == '0)                 state_d = S_DONE;
                    else                                 state_d = S_READ;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  if (ex_valid_i) state_d = S_WRITE;
            S_WRITE: state_d = last_word ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            vd_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            sew_q   <= '0;
            rem_q   <= '0;
            word_q  <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        vd_q   <= vd_i;
                        vs1_q  <= vs1_i;
                        vs2_q  <= vs2_i;
                        sew_q  <= vsew_i[1:0];
                        rem_q  <= vl_i;
                        word_q <= '0;
                    end
                end
                // Operands are registered on the way into EXEC so EX sees them stable.
                S_READ: begin
                    op_a_q  <= vrf_rdata2_i;
                    op_b_q  <= vrf_rdata1_i;
                    first_q <= 1'b1;
                end
                S_EXEC: begin
                    first_q <= 1'b0;
                    if (ex_valid_i) res_q <= ex_result_i;
                end
                S_WRITE: begin
                    if (!last_word) begin
                        rem_q  <= rem_q - elems;
                        word_q <= word_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o          = (state_q == S_IDLE);
    assign busy_o           = (state_q != S_IDLE);
    assign vrf_re_o         = (state_q == S_READ);
    assign vrf_ra1_o        = vrf_re_o ? vs1_q : '0;
    assign vrf_ra2_o        = vrf_re_o ? vs2_q : '0;
    assign vrf_rword_o      = vrf_re_o ? word_q : '0;
    assign ex_operand_a_o   = (state_q == S_EXEC) ? op_a_q : '0;
    assign ex_operand_b_o   = (state_q == S_EXEC) ? op_b_q : '0;
    assign ex_first_cycle_o = (state_q == S_EXEC) && first_q;
    assign vrf_we_o         = (state_q == S_WRITE);
    assign vrf_wa_o         = vrf_we_o ? vd_q : '0;
    assign vrf_wword_o      = vrf_we_o ? word_q : '0;
    assign vrf_wdata_o      = vrf_we_o ? res_q : '0;
    assign vrf_wbe_o        = vrf_we_o ? wbe : '0;
    assign done_o           = (state_q == S_DONE);
    assign err_o            = (state_q == S_ERR);
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_vcve2_vec_ex_seq.sv
// Directed bench for vcve2_vec_ex_seq: VRF and EX responders, cycle-stamped scoreboard
// of expected reads, operands and writes, and a single summary line.
module tb_vcve2_vec_ex_seq;
    localparam int VLEN   = 128;
    localparam int NWORDS = 4;
    localparam int WORD_W = 2;
    localparam int VL_W   = 5;

    logic              clk = 1'b0;
    logic              rst_i, start_i;
    logic              ready_o, busy_o;
    logic [4:0]        vd_i, vs1_i, vs2_i;
    logic [VL_W-1:0]   vl_i;
    logic [2:0]        vsew_i;
    logic              vrf_re_o;
    logic [4:0]        vrf_ra1_o, vrf_ra2_o;
    logic [WORD_W-1:0] vrf_rword_o;
    logic [31:0]       vrf_rdata1_i, vrf_rdata2_i;
    logic [31:0]       ex_operand_a_o, ex_operand_b_o;
    logic              ex_first_cycle_o, ex_valid_i;
    logic [31:0]       ex_result_i;
    logic              vrf_we_o;
    logic [4:0]        vrf_wa_o;
    logic [WORD_W-1:0] vrf_wword_o;
    logic [31:0]       vrf_wdata_o;
    logic [3:0]        vrf_wbe_o;
    logic              done_o, err_o;
    logic [2:0]        dbg_state_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int ex_dly = 0;
    int ex_cnt = 0;
    int done_cnt, err_cnt, done_cyc, err_cyc, wr_cnt;
    bit in_exec = 1'b0;
    logic [63:0] cur_op;
    logic [3:0]  last_wbe;
    logic [1:0]  last_wword;
    logic [31:0] first_wdata;

    logic [31:0] mem [32][NWORDS];
    logic [19:0] exp_rd_q[$];
    logic [63:0] exp_op_q[$];
    logic [50:0] exp_wr_q[$];

    vcve2_vec_ex_seq #(.VLEN(VLEN)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .ready_o(ready_o), .busy_o(busy_o),
        .vd_i(vd_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .vl_i(vl_i), .vsew_i(vsew_i),
        .vrf_re_o(vrf_re_o), .vrf_ra1_o(vrf_ra1_o), .vrf_ra2_o(vrf_ra2_o),
        .vrf_rword_o(vrf_rword_o), .vrf_rdata1_i(vrf_rdata1_i), .vrf_rdata2_i(vrf_rdata2_i),
        .ex_operand_a_o(ex_operand_a_o), .ex_operand_b_o(ex_operand_b_o),
        .ex_first_cycle_o(ex_first_cycle_o), .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i),
        .vrf_we_o(vrf_we_o), .vrf_wa_o(vrf_wa_o), .vrf_wword_o(vrf_wword_o),
        .vrf_wdata_o(vrf_wdata_o), .vrf_wbe_o(vrf_wbe_o), .done_o(done_o), .err_o(err_o),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    // VRF read data follows the addressed word; EX adds its operands.
    assign vrf_rdata1_i = mem[vrf_ra1_o][vrf_rword_o];
    assign vrf_rdata2_i = mem[vrf_ra2_o][vrf_rword_o];
    assign ex_result_i  = ex_operand_a_o + ex_operand_b_o;
    assign ex_valid_i   = (ex_dly == 0) ? 1'b1 : (!ex_first_cycle_o && (ex_cnt == ex_dly));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ex_first_cycle_o) ex_cnt <= 1;
        else if (ex_cnt != 0 && ex_cnt < 1000) ex_cnt <= ex_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        int rel;
        rel = cyc - t0;
        if (vrf_re_o === 1'b1) begin
            chk("read_expected", 64'(exp_rd_q.size() != 0), 64'd1);
            if (exp_rd_q.size() != 0)
                chk("read", {rel[7:0], vrf_ra1_o, vrf_ra2_o, vrf_rword_o}, exp_rd_q.pop_front());
        end
        if (vrf_we_o === 1'b1) begin
            chk("write_expected", 64'(exp_wr_q.size() != 0), 64'd1);
            if (exp_wr_q.size() != 0)
                chk("write", {rel[7:0], vrf_wa_o, vrf_wword_o, vrf_wdata_o, vrf_wbe_o},
                    exp_wr_q.pop_front());
            if (wr_cnt == 0) first_wdata = vrf_wdata_o;
            wr_cnt++;
            last_wbe   = vrf_wbe_o;
            last_wword = vrf_wword_o;
        end
        if (ex_first_cycle_o === 1'b1) begin
            chk("first_once", 64'(in_exec), 64'd0);
            chk("op_expected", 64'(exp_op_q.size() != 0), 64'd1);
            if (exp_op_q.size() != 0) cur_op = exp_op_q.pop_front();
            in_exec = 1'b1;
        end
        if (in_exec) begin
            chk("operands", {ex_operand_a_o, ex_operand_b_o}, cur_op);
            if (ex_valid_i === 1'b1) in_exec = 1'b0;
        end
        if (done_o === 1'b1) begin done_cnt++; done_cyc = rel; end
        if (err_o === 1'b1) begin err_cnt++; err_cyc = rel; end
    end

    task automatic run(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [VL_W-1:0] vl, input logic [2:0] sew, input int dly,
                       input int pulse_at, input int rst_at, input int exp_end,
                       input bit exp_err);
        int e, b, words, rem, rc, wc, last_n;
        logic [3:0]  be;
        logic [31:0] wd;
        e = (sew == 3'b000) ? 4 : (sew == 3'b001) ? 2 : 1;
        b = 4 / e;
        ex_dly = dly;
        if (!exp_err) begin
            words = (int'(vl) + e - 1) / e;
            rem = int'(vl);
            for (int k = 0; k < words; k++) begin
                rc = 1 + k * (3 + dly);
                wc = rc + 2 + dly;
                be = (rem >= e) ? 4'hF : 4'((1 << (rem * b)) - 1);
                wd = mem[vs2][k] + mem[vs1][k];
                if (rst_at < 0 || rc <= rst_at) exp_rd_q.push_back({8'(rc), vs1, vs2, 2'(k)});
                if (rst_at < 0 || rc + 1 <= rst_at) exp_op_q.push_back({mem[vs2][k], mem[vs1][k]});
                if (rst_at < 0 || wc <= rst_at) exp_wr_q.push_back({8'(wc), vd, 2'(k), wd, be});
                rem -= e;
            end
        end
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1; wr_cnt = 0;
        @(posedge clk); #1;
        vd_i = vd; vs1_i = vs1; vs2_i = vs2; vl_i = vl; vsew_i = sew; start_i = 1'b1;
        t0 = cyc;
        last_n = (rst_at >= 0) ? rst_at + 4 : exp_end + 3;
        for (int n = 1; n <= last_n; n++) begin
            @(posedge clk); #1;
            start_i = (n == pulse_at);
            vd_i = (n == pulse_at) ? 5'd31 : vd;
            rst_i = (n == rst_at);
            if (rst_at >= 0 && n == rst_at + 1) begin
                chk("rst_ready", 64'(ready_o), 64'd1);
                chk("rst_busy", 64'(busy_o), 64'd0);
                in_exec = 1'b0;
            end
        end
        if (exp_err) begin
            chk("err_cyc", 64'(err_cyc), 64'(exp_end));
            chk("err_cnt", 64'(err_cnt), 64'd1);
            chk("done_cnt", 64'(done_cnt), 64'd0);
        end else if (rst_at >= 0) begin
            chk("done_cnt_rst", 64'(done_cnt), 64'd0);
            chk("err_cnt_rst", 64'(err_cnt), 64'd0);
        end else begin
            chk("done_cyc", 64'(done_cyc), 64'(exp_end));
            chk("done_cnt", 64'(done_cnt), 64'd1);
            chk("err_cnt", 64'(err_cnt), 64'd0);
        end
        chk("rd_left", 64'(exp_rd_q.size()), 64'd0);
        chk("op_left", 64'(exp_op_q.size()), 64'd0);
        chk("wr_left", 64'(exp_wr_q.size()), 64'd0);
        chk("end_ready", 64'(ready_o), 64'd1);
        exp_rd_q.delete(); exp_op_q.delete(); exp_wr_q.delete();
    endtask

    initial begin
        int e, words, dly;
        logic [VL_W-1:0] vl;
        logic [2:0] sew;
        for (int r = 0; r < 32; r++)
            for (int w = 0; w < NWORDS; w++) mem[r][w] = $urandom;
        mem[6][0] = 32'h0003_0002;
        mem[5][0] = 32'h0001_0001;

        // Clock/reset
        rst_i = 1'b1; start_i = 1'b0; vd_i = '0; vs1_i = '0; vs2_i = '0; vl_i = '0; vsew_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_re", 64'(vrf_re_o), 64'd0);
        chk("rst_we", 64'(vrf_we_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_first", 64'(ex_first_cycle_o), 64'd0);
        chk("rst_opa", 64'(ex_operand_a_o), 64'd0);
        chk("rst_wbe", 64'(vrf_wbe_o), 64'd0);
        chk("rst_state", 64'(dbg_state_o), 64'd0);
        rst_i = 1'b0;

        // Full sew8 register, single-cycle EX
        run(5'd3, 5'd1, 5'd2, 5'd16, 3'b000, 0, -1, -1, 13, 1'b0);
        chk("t1_last_wbe", 64'(last_wbe), 64'hF);
        chk("t1_last_wword", 64'(last_wword), 64'd3);

        // sew16 tail word
        run(5'd4, 5'd5, 5'd6, 5'd5, 3'b001, 0, -1, -1, 10, 1'b0);
        chk("t2_word0", 64'(first_wdata), 64'h0004_0003);
        chk("t2_last_wbe", 64'(last_wbe), 64'b0011);
        chk("t2_last_wword", 64'(last_wword), 64'd2);

        // Multi-cycle EX
        run(5'd7, 5'd8, 5'd9, 5'd2, 3'b010, 3, -1, -1, 13, 1'b0);

        // vl=0 and illegal configurations
        run(5'd1, 5'd2, 5'd3, 5'd0, 3'b000, 0, -1, -1, 1, 1'b0);
        run(5'd1, 5'd2, 5'd3, 5'd4, 3'b011, 0, -1, -1, 1, 1'b1);
        run(5'd1, 5'd2, 5'd3, 5'd17, 3'b000, 0, -1, -1, 1, 1'b1);
        run(5'd1, 5'd2, 5'd3, 5'd5, 3'b010, 0, -1, -1, 1, 1'b1);

        // Reset during EXEC of word 1, then a normal instruction
        run(5'd10, 5'd11, 5'd12, 5'd8, 3'b000, 3, -1, 9, -1, 1'b0);
        run(5'd13, 5'd14, 5'd15, 5'd7, 3'b000, 1, -1, -1, 9, 1'b0);
        chk("t8_last_wbe", 64'(last_wbe), 64'b0111);

        // start pulsed during WRITE is ignored
        run(5'd9, 5'd16, 5'd17, 5'd2, 3'b010, 0, 3, -1, 7, 1'b0);

        for (int i = 0; i < 5; i++) begin
            sew = 3'($urandom_range(0, 2));
            e = (sew == 3'b000) ? 4 : (sew == 3'b001) ? 2 : 1;
            vl = VL_W'($urandom_range(1, NWORDS * e));
            dly = $urandom_range(0, 2);
            words = (int'(vl) + e - 1) / e;
            run(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                vl, sew, dly, -1, -1, 1 + words * (3 + dly), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
